// File: rtl/mem_bus_pkg.sv
// Shared types and timing defaults for the external SRAM bus initiator.
package mem_bus_pkg;

    // Bus sequencer states: a store walks SETUP -> STROBE -> HOLD, a load waits in R_WAIT.
    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_WAIT
    } mem_state_t;

    // Default bus geometry and SRAM cycle timing.
    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_SETUP_CYC  = 1;
    localparam int unsigned DEF_STROBE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC   = 1;
    localparam int unsigned DEF_READ_CYC   = 2;

    // Width of a down-counter that must hold values 0..max (never narrower than 1 bit).
    function automatic int unsigned cnt_w(input int unsigned max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage : mem_bus_pkg

// File: rtl/mem_wait_counter.sv
// Loadable down-counter shared by every timed bus state; stops at zero.
module mem_wait_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule : mem_wait_counter

// File: rtl/mem_bus_ctrl.sv
// Processor-side initiator for the asynchronous SRAM bus: turns single-cycle
// load/store requests into timed setup/strobe/hold or read-wait sequences.
// Every pin is a flop output, so nothing combinational reaches the pads.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned READ_CYC   = DEF_READ_CYC
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in
);

    // A zero-length stage would collapse the SRAM timing, so refuse to elaborate.
    if (SETUP_CYC == 0 || STROBE_CYC == 0 || HOLD_CYC == 0 || READ_CYC == 0) begin : g_param_check
        $error("mem_bus_ctrl: SETUP_CYC, STROBE_CYC, HOLD_CYC and READ_CYC must all be >= 1");
    end

    // The timer is loaded with (stage length - 1), so size it for the largest such value.
    localparam int unsigned MAX_A  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_B  = (HOLD_CYC > READ_CYC) ? HOLD_CYC : READ_CYC;
    localparam int unsigned MAX_LD = ((MAX_A > MAX_B) ? MAX_A : MAX_B) - 1;
    localparam int unsigned TW     = cnt_w(MAX_LD);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_write_q, mem_write_d;
    logic              data_oe_q, data_oe_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;

    logic              tmr_load;
    logic [TW-1:0]     tmr_value;
    logic              tmr_dec;
    logic              tmr_zero;

    mem_wait_counter #(
        .W (TW)
    ) u_timer (
        .clk_i   (clk1),
        .rst_ni  (reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    // State and pin registers; reset drops the strobe and bus drive without waiting for a clock.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            wdata_q     <= '0;
            data_out_q  <= '0;
            rdata_q     <= '0;
            mem_write_q <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            data_out_q  <= data_out_d;
            rdata_q     <= rdata_d;
            mem_write_q <= mem_write_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
        end
    end

    // Next-state and next-pin logic; mem_write/data_oe are always set together so
    // the core and the SRAM never drive MemData at the same time.
    always_comb begin
        // NOTE: every variable gets a default before the case so no branch can infer a latch.
        state_d     = state_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        data_out_d  = data_out_q;
        rdata_d     = rdata_q;
        mem_write_d = 1'b0;
        data_oe_d   = 1'b0;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        tmr_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req) begin
                    adr_d    = req_addr;
                    wdata_d  = req_wdata;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    if (req_we) begin
                        state_d   = W_SETUP;
                        tmr_value = TW'(SETUP_CYC - 1);
                    end else begin
                        state_d   = R_WAIT;
                        tmr_value = TW'(READ_CYC - 1);
                    end
                end
            end

            W_SETUP: begin
                if (tmr_zero) begin
                    state_d     = W_STROBE;
                    tmr_load    = 1'b1;
                    tmr_value   = TW'(STROBE_CYC - 1);
                    mem_write_d = 1'b1;
                    data_oe_d   = 1'b1;
                    data_out_d  = wdata_q;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            W_STROBE: begin
                if (tmr_zero) begin
                    state_d   = W_HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(HOLD_CYC - 1);
                end else begin
                    tmr_dec     = 1'b1;
                    mem_write_d = 1'b1;
                    data_oe_d   = 1'b1;
                end
            end

            W_HOLD: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            R_WAIT: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    rdata_d = data_in;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_write = mem_write_q;
    assign adr       = adr_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;

endmodule : mem_bus_ctrl

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: two instances (default and stretched
// timing) share one stimulus port and one SRAM model, selected by 'sel'.
module tb_mem_bus_ctrl;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        int          acc;
    } txn_t;

    logic        clk1 = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;

    logic        busy1, ack1, mw1, oe1, busy2, ack2, mw2, oe2;
    logic [15:0] rdata1, dout1, rdata2, dout2;
    logic [7:0]  adr1, adr2;
    logic [15:0] data_in_w;
    logic        req1, req2;

    logic        busy_s, ack_s, mw_s, oe_s;
    logic [15:0] rdata_s, dout_s;
    logic [7:0]  adr_s;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          write_count = 0;
    txn_t        sb[$];
    logic [15:0] sram [256];
    logic        sram_ready = 1'b0;
    logic [15:0] ref_mem [int];

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    assign req1 = req & ~sel;
    assign req2 = req & sel;

    assign busy_s  = sel ? busy2  : busy1;
    assign ack_s   = sel ? ack2   : ack1;
    assign mw_s    = sel ? mw2    : mw1;
    assign oe_s    = sel ? oe2    : oe1;
    assign rdata_s = sel ? rdata2 : rdata1;
    assign dout_s  = sel ? dout2  : dout1;
    assign adr_s   = sel ? adr2   : adr1;

    mem_bus_ctrl dut (
        .clk1 (clk1), .reset (reset), .req (req1), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata), .busy (busy1), .ack (ack1),
        .rdata (rdata1), .mem_write (mw1), .adr (adr1), .data_out (dout1),
        .data_oe (oe1), .data_in (data_in_w)
    );

    mem_bus_ctrl #(
        .SETUP_CYC (2), .STROBE_CYC (3), .HOLD_CYC (2), .READ_CYC (1)
    ) dut2 (
        .clk1 (clk1), .reset (reset), .req (req2), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata), .busy (busy2), .ack (ack2),
        .rdata (rdata2), .mem_write (mw2), .adr (adr2), .data_out (dout2),
        .data_oe (oe2), .data_in (data_in_w)
    );

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 16'h0101) ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] ref_word(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Asynchronous SRAM: combinational read, written while the initiator strobes.
    assign data_in_w = sram[adr_s];
    always @(posedge clk1) begin
        if (!sram_ready) begin
            for (int i = 0; i < 256; i++) sram[i] = init_word(i);
            sram_ready = 1'b1;
        end else if (mw_s && oe_s) begin
            sram[adr_s] = dout_s;
        end
    end

    // Bus monitor and scoreboard consumer, sampled on the falling edge.
    logic prev_mw = 1'b0;
    int   strobe_len = 0;
    always @(negedge clk1) begin
        int   exp_setup, exp_strobe, exp_lat;
        txn_t t;
        exp_setup  = sel ? 2 : 1;
        exp_strobe = sel ? 3 : 2;
        if (!reset) begin
            prev_mw    = 1'b0;
            strobe_len = 0;
        end else begin
            n_checks++;
            if (oe_s !== mw_s) begin
                n_fail++;
                $display("FAIL bus_own t=%0t: data_oe=%b mem_write=%b", $time, oe_s, mw_s);
            end
            if (mw_s === 1'b1) begin
                n_checks++;
                if (sb.size() == 0 || sb[0].we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL strobe_owner t=%0t: mem_write=1 with no store in flight", $time);
                end else begin
                    if (!prev_mw) begin
                        n_checks++;
                        if (cyc - sb[0].acc != exp_setup) begin
                            n_fail++;
                            $display("FAIL strobe_start: got %0d cycles after accept, want %0d", cyc - sb[0].acc, exp_setup);
                        end
                    end
                    n_checks++;
                    if (adr_s !== sb[0].addr || dout_s !== sb[0].data) begin
                        n_fail++;
                        $display("FAIL strobe_bus: adr=%h data_out=%h, want adr=%h data_out=%h", adr_s, dout_s, sb[0].addr, sb[0].data);
                    end
                end
                strobe_len++;
            end else if (prev_mw) begin
                n_checks++;
                if (strobe_len != exp_strobe) begin
                    n_fail++;
                    $display("FAIL strobe_width: got %0d cycles, want %0d", strobe_len, exp_strobe);
                end
                write_count++;
                strobe_len = 0;
            end
            if (ack_s === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack t=%0t: ack=1 with nothing outstanding", $time);
                end else begin
                    t = sb.pop_front();
                    exp_lat = t.we ? (sel ? 7 : 4) : (sel ? 1 : 2);
                    if (cyc - t.acc != exp_lat) begin
                        n_fail++;
                        $display("FAIL ack_latency: got %0d, want %0d (we=%b addr=%h)", cyc - t.acc, exp_lat, t.we, t.addr);
                    end
                    n_checks++;
                    if (t.we) begin
                        ref_mem[int'(t.addr)] = t.data;
                        if (sram[t.addr] !== t.data) begin
                            n_fail++;
                            $display("FAIL sram_word: mem[%h]=%h, want %h", t.addr, sram[t.addr], t.data);
                        end
                    end else if (rdata_s !== ref_word(int'(t.addr))) begin
                        n_fail++;
                        $display("FAIL load_data: rdata=%h, want %h (addr %h)", rdata_s, ref_word(int'(t.addr)), t.addr);
                    end
                end
            end
            prev_mw = mw_s;
        end
    end

    // Present a request and record it in the scoreboard at the accepting edge.
    task automatic issue(input logic we, input logic [7:0] a, input logic [15:0] d);
        txn_t t;
        req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(posedge clk1); #1;
        t.we = we; t.addr = a; t.data = d; t.acc = cyc;
        sb.push_back(t);
        n_checks++;
        if (busy_s !== 1'b1 || adr_s !== a) begin
            n_fail++;
            $display("FAIL accept: busy=%b adr=%h, want busy=1 adr=%h", busy_s, adr_s, a);
        end
    endtask

    // Wait (bounded) for ack; leaves the caller on the falling edge of the ack cycle.
    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk1);
            n++;
        end while (ack_s !== 1'b1 && n < 50);
        n_checks++;
        if (ack_s !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_timeout: ack=%b after %0d cycles, want 1", ack_s, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk1);
        n_checks++;
        if ({mw_s, oe_s, busy_s, ack_s} !== 4'b0 || adr_s !== 8'h00 || dout_s !== 16'h0 || rdata_s !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: mw=%b oe=%b busy=%b ack=%b adr=%h dout=%h rdata=%h, want all 0",
                     mw_s, oe_s, busy_s, ack_s, adr_s, dout_s, rdata_s);
        end
        #1 reset = 1'b1;
        @(negedge clk1);
    endtask

    task automatic test_store_load();
        issue(1'b1, 8'h3C, 16'hBEEF);
        wait_ack();
        req = 1'b0;
        @(negedge clk1);
        issue(1'b0, 8'h3C, 16'h0000);
        wait_ack();
        req = 1'b0;
        n_checks++;
        if (rdata_s !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_after_store: rdata=%h, want beef", rdata_s);
        end
        repeat (3) @(negedge clk1);
        n_checks++;
        if (rdata_s !== 16'hBEEF || busy_s !== 1'b0) begin
            n_fail++;
            $display("FAIL rdata_hold: rdata=%h busy=%b, want beef and 0", rdata_s, busy_s);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 8'hFF, 16'h0001);
        wait_ack();
        issue(1'b0, 8'hFF, 16'h0000);
        wait_ack();
        req = 1'b0;
        n_checks++;
        if (rdata_s !== 16'h0001) begin
            n_fail++;
            $display("FAIL b2b_load: rdata=%h, want 0001", rdata_s);
        end
        repeat (2) @(negedge clk1);
    endtask

    task automatic test_busy_ignore();
        int wc0 = write_count;
        issue(1'b1, 8'h3C, 16'h5A5A);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk1);
            req = ~req; req_addr = 8'h55; req_we = 1'b0; req_wdata = 16'hFFFF;
        end
        wait_ack();
        req = 1'b0;
        repeat (4) @(negedge clk1);
        n_checks++;
        if (write_count - wc0 != 1) begin
            n_fail++;
            $display("FAIL write_count: got %0d SRAM writes, want 1", write_count - wc0);
        end
        n_checks++;
        if (sram[8'h55] !== init_word(8'h55) || sram[8'h3C] !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL busy_ignore: mem[55]=%h mem[3c]=%h, want %h and 5a5a", sram[8'h55], sram[8'h3C], init_word(8'h55));
        end
    endtask

    task automatic test_reset_mid_strobe();
        int n = 0;
        issue(1'b1, 8'h20, 16'h1234);
        while (mw_s !== 1'b1 && n < 20) begin
            @(negedge clk1);
            n++;
        end
        n_checks++;
        if (mw_s !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_timeout: mem_write=%b, want 1", mw_s);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({mw_s, oe_s, busy_s, ack_s} !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset: mw=%b oe=%b busy=%b ack=%b, want all 0", mw_s, oe_s, busy_s, ack_s);
        end
        sb.delete();
        req = 1'b0;
        repeat (2) @(negedge clk1);
        #2 reset = 1'b1;
        @(negedge clk1);
        issue(1'b0, 8'h10, 16'h0000);
        wait_ack();
        req = 1'b0;
        n_checks++;
        if (rdata_s !== init_word(8'h10)) begin
            n_fail++;
            $display("FAIL post_reset_load: rdata=%h, want %h", rdata_s, init_word(8'h10));
        end
        @(negedge clk1);
    endtask

    task automatic test_alt_params();
        sel = 1'b1;
        @(negedge clk1);
        issue(1'b1, 8'h80, 16'hCAFE);
        wait_ack();
        req = 1'b0;
        @(negedge clk1);
        issue(1'b0, 8'h80, 16'h0000);
        wait_ack();
        req = 1'b0;
        n_checks++;
        if (rdata_s !== 16'hCAFE) begin
            n_fail++;
            $display("FAIL alt_load: rdata=%h, want cafe", rdata_s);
        end
        issue(1'b0, 8'h01, 16'h0000);
        wait_ack();
        req = 1'b0;
        repeat (3) @(negedge clk1);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL outstanding: %0d requests never acked, want 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_strobe();
        test_alt_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_bus_ctrl
